// File: rtl/fft_pkg.sv
// Shared FFT front-end definitions: default geometry, complex word layout,
// read FSM states and the bit-reversal helper.
package fft_pkg;

  localparam int FFT_N        = 32;
  localparam int FFT_SAMPLE_W = 11;
  localparam int FFT_LOG2N    = $clog2(FFT_N);
  localparam int FFT_DATA_W   = FFT_SAMPLE_W + FFT_LOG2N;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } rd_state_t;

  function automatic int unsigned bitrev(input int unsigned a, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = r | (((a >> i) & 1) << (bits - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// N x SAMPLE_W sample store: single write port, one registered read port that
// returns an even/odd address pair per line.
module fft_sample_bank #(
  parameter int N        = 32,
  parameter int SAMPLE_W = 11
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [SAMPLE_W-1:0]  wdata,
  input  logic                 re,
  input  logic [$clog2(N)-2:0] raddr,
  output logic [SAMPLE_W-1:0]  rdata_even,
  output logic [SAMPLE_W-1:0]  rdata_odd
);

  localparam int AW = $clog2(N);

  logic [SAMPLE_W-1:0] mem_even [N/2];
  logic [SAMPLE_W-1:0] mem_odd  [N/2];

  always_ff @(posedge clk) begin
    if (we && !waddr[0]) mem_even[waddr[AW-1:1]] <= wdata;
    if (we &&  waddr[0]) mem_odd[waddr[AW-1:1]]  <= wdata;
    if (re) begin
      rdata_even <= mem_even[raddr];
      rdata_odd  <= mem_odd[raddr];
    end
  end

endmodule

// File: rtl/fft_input_buffer.sv
// FFT input buffer: ping-pong bit-reversed sample store that streams
// butterfly input pairs (x[k], x[k+N/2]) with a valid/ready handshake.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int N        = FFT_N,
  parameter int SAMPLE_W = FFT_SAMPLE_W,
  parameter int DATA_W   = FFT_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SAMPLE_W-1:0]  sample_in,
  input  logic                 sample_valid,
  input  logic                 pair_ready,
  output logic                 pair_valid,
  output logic [2*DATA_W-1:0]  A_out,
  output logic [2*DATA_W-1:0]  B_out,
  output logic [$clog2(N)-2:0] pair_idx,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int AW = $clog2(N);
  localparam int KW = AW - 1;

  rd_state_t           state, state_nxt;
  logic [AW-1:0]       w;
  logic                fb, rb;
  logic [1:0]          full, set_full, clr_full;
  logic [KW-1:0]       k;
  logic                held;
  logic                accept, xfer, last_pair;
  logic [AW-1:0]       waddr;
  logic [KW-1:0]       raddr;
  logic [1:0]          we, re;
  logic [SAMPLE_W-1:0] even0, odd0, even1, odd1, even_q, odd_q;
  cplx_t               a_word, b_word;

  assign accept    = sample_valid && !full[fb];
  assign xfer      = (state == STREAM) && pair_ready;
  assign last_pair = xfer && (k == KW'(N/2 - 1));
  assign waddr     = AW'(bitrev(32'(w), AW));
  // x[k] lands at bitrev(k) (even) and x[k+N/2] right after it, so the
  // line index is simply k reversed over the upper address bits.
  assign raddr     = KW'(bitrev(32'(k), KW));

  assign we       = accept ? (2'b01 << fb) : 2'b00;
  assign re       = (state == FETCH) ? (2'b01 << rb) : 2'b00;
  assign set_full = (accept && (w == AW'(N - 1))) ? (2'b01 << fb) : 2'b00;
  assign clr_full = last_pair ? (2'b01 << rb) : 2'b00;

  fft_sample_bank #(.N(N), .SAMPLE_W(SAMPLE_W)) u_bank0 (
    .clk(clk), .we(we[0]), .waddr(waddr), .wdata(sample_in),
    .re(re[0]), .raddr(raddr), .rdata_even(even0), .rdata_odd(odd0)
  );

  fft_sample_bank #(.N(N), .SAMPLE_W(SAMPLE_W)) u_bank1 (
    .clk(clk), .we(we[1]), .waddr(waddr), .wdata(sample_in),
    .re(re[1]), .raddr(raddr), .rdata_even(even1), .rdata_odd(odd1)
  );

  assign even_q = rb ? even1 : even0;
  assign odd_q  = rb ? odd1  : odd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rb]) state_nxt = FETCH;
      FETCH:   state_nxt = STREAM;
      STREAM:  if (xfer) state_nxt = last_pair ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w          <= '0;
      fb         <= 1'b0;
      rb         <= 1'b0;
      full       <= '0;
      k          <= '0;
      held       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      full       <= (full | set_full) & ~clr_full;
      held       <= (state == STREAM) && !pair_ready;
      frame_done <= last_pair;
      if (sample_valid && full[fb]) overflow <= 1'b1;
      if (accept) begin
        if (w == AW'(N - 1)) begin
          w  <= '0;
          fb <= ~fb;
        end else begin
          w <= w + 1'b1;
        end
      end
      if (xfer) begin
        if (last_pair) begin
          k  <= '0;
          rb <= ~rb;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  always_comb begin
    a_word = '0;
    b_word = '0;
    if (pair_valid) begin
      a_word.re = {{(DATA_W-SAMPLE_W){even_q[SAMPLE_W-1]}}, even_q};
      b_word.re = {{(DATA_W-SAMPLE_W){odd_q[SAMPLE_W-1]}}, odd_q};
    end
  end

  assign pair_valid  = (state == STREAM);
  assign A_out       = a_word;
  assign B_out       = b_word;
  assign pair_idx    = k;
  assign frame_start = pair_valid && (k == '0) && !held;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer: random frames against a
// frame-level reference of expected butterfly pairs.
module tb_fft_input_buffer;

  localparam int N  = 32;
  localparam int SW = 11;
  localparam int DW = 16;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          pair_ready = 1'b0;
  logic          pair_valid;
  logic [2*DW-1:0] A_out, B_out;
  logic [KW-1:0] pair_idx;
  logic          frame_start, frame_done, overflow;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  int smp [96];
  logic [2*DW-1:0] exp_a [$];
  logic [2*DW-1:0] exp_b [$];
  int              exp_k [$];
  logic [2*DW-1:0] got_a [$];
  logic [2*DW-1:0] got_b [$];
  int              got_k [$];
  int              got_cyc [$];
  int fs_cnt = 0, fs_idx = -1, fd_cnt = 0, fd_cyc = -1;

  fft_input_buffer #(.N(N), .SAMPLE_W(SW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .pair_ready(pair_ready), .pair_valid(pair_valid), .A_out(A_out), .B_out(B_out),
    .pair_idx(pair_idx), .frame_start(frame_start), .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer recorder: a pair is taken at the next rising edge when valid&&ready here.
  always @(negedge clk) begin
    if (pair_valid && pair_ready) begin
      got_a.push_back(A_out);
      got_b.push_back(B_out);
      got_k.push_back(int'(pair_idx));
      got_cyc.push_back(cyc);
    end
    if (frame_start) begin
      fs_cnt++;
      fs_idx = int'(pair_idx);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v, input int gap);
    sample_in    = SW'(v);
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    step(gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic clear_mon();
    got_a.delete(); got_b.delete(); got_k.delete(); got_cyc.delete();
    exp_a.delete(); exp_b.delete(); exp_k.delete();
    fs_cnt = 0; fs_idx = -1; fd_cnt = 0; fd_cyc = -1;
  endtask

  // Pair k of a frame is (x[k], x[k+N/2]) with the real part sign-extended, imag 0.
  task automatic expect_frame(input int f);
    for (int k = 0; k < N/2; k++) begin
      exp_a.push_back({16'(smp[f*N + k]), 16'h0000});
      exp_b.push_back({16'(smp[f*N + k + N/2]), 16'h0000});
      exp_k.push_back(k);
    end
  endtask

  task automatic randomize_samples(input int count);
    for (int i = 0; i < count; i++) smp[i] = int'($urandom_range(2047)) - 1024;
  endtask

  task automatic wait_pairs(input int n, input int budget, output bit to);
    int b;
    b = budget;
    while (got_a.size() < n && b > 0) begin
      step(1);
      b--;
    end
    to = (got_a.size() < n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    checks++; if (pair_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", pair_valid); else passed++;
    checks++; if (A_out !== '0 || B_out !== '0) $display("FAIL reset_data got A=%h B=%h want 0", A_out, B_out); else passed++;
    checks++; if (pair_idx !== '0) $display("FAIL reset_idx got=%0d want=0", pair_idx); else passed++;
    checks++; if (frame_start !== 1'b0 || frame_done !== 1'b0) $display("FAIL reset_pulses got fs=%b fd=%b want 0", frame_start, frame_done); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b want=0", overflow); else passed++;
    rst_n = 1'b1;
    step(3);
    checks++; if (pair_valid !== 1'b0) $display("FAIL idle_valid got=%b want=0", pair_valid); else passed++;
  endtask

  task automatic test_ramp();
    bit to;
    int bad;
    clear_mon();
    pair_ready = 1'b1;
    for (int i = 0; i < N; i++) smp[i] = i;
    expect_frame(0);
    for (int i = 0; i < N; i++) send(smp[i], 0);
    checks++; if (pair_valid !== 1'b0) $display("FAIL latency_e0 got=%b want=0", pair_valid); else passed++;
    step(1);
    checks++; if (pair_valid !== 1'b0) $display("FAIL latency_e1 got=%b want=0", pair_valid); else passed++;
    step(1);
    checks++; if (pair_valid !== 1'b1 || frame_start !== 1'b1) $display("FAIL latency_e2 got v=%b fs=%b want 1 1", pair_valid, frame_start); else passed++;
    wait_pairs(16, 100, to);
    checks++; if (to) $display("FAIL ramp_timeout got=%0d pairs want=16", got_a.size()); else passed++;
    if (!to) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_k[i] !== exp_k[i])
          $display("FAIL ramp_pair%0d got A=%h B=%h k=%0d want A=%h B=%h k=%0d", i, got_a[i], got_b[i], got_k[i], exp_a[i], exp_b[i], exp_k[i]);
        else passed++;
      end
      bad = 0;
      for (int i = 1; i < 16; i++) if (got_cyc[i] - got_cyc[i-1] != 2) bad++;
      checks++; if (bad != 0) $display("FAIL ramp_throughput got=%0d gaps!=2 want=0", bad); else passed++;
      step(2);
      checks++; if (fd_cnt != 1 || fd_cyc != got_cyc[15] + 1) $display("FAIL ramp_frame_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", fd_cnt, fd_cyc, got_cyc[15] + 1); else passed++;
    end
    checks++; if (fs_cnt != 1 || fs_idx != 0) $display("FAIL ramp_frame_start got cnt=%0d idx=%0d want 1 0", fs_cnt, fs_idx); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL ramp_overflow got=%b want=0", overflow); else passed++;
  endtask

  task automatic test_extremes();
    bit to;
    clear_mon();
    pair_ready = 1'b1;
    randomize_samples(N);
    smp[0] = 1023; smp[16] = -1024; smp[5] = -1024; smp[21] = 1023;
    expect_frame(0);
    for (int i = 0; i < N; i++) send(smp[i], int'($urandom_range(2)));
    wait_pairs(16, 100, to);
    checks++; if (to) $display("FAIL ext_timeout got=%0d pairs want=16", got_a.size()); else passed++;
    if (!to) begin
      checks++; if (got_a[0] !== 32'h03FF_0000 || got_b[0] !== 32'hFC00_0000) $display("FAIL ext_k0 got A=%h B=%h want 03ff0000 fc000000", got_a[0], got_b[0]); else passed++;
      checks++; if (got_a[5] !== 32'hFC00_0000 || got_b[5] !== 32'h03FF_0000) $display("FAIL ext_k5 got A=%h B=%h want fc000000 03ff0000", got_a[5], got_b[5]); else passed++;
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_k[i] !== exp_k[i])
          $display("FAIL ext_pair%0d got A=%h B=%h k=%0d want A=%h B=%h k=%0d", i, got_a[i], got_b[i], got_k[i], exp_a[i], exp_b[i], exp_k[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    int hold, unstable, budget, k3;
    logic [2*DW-1:0] ca, cb;
    logic [KW-1:0] ck;
    clear_mon();
    pair_ready = 1'b1;
    randomize_samples(N);
    expect_frame(0);
    for (int i = 0; i < N; i++) send(smp[i], 0);
    hold = 0; unstable = 0; budget = 200;
    ca = '0; cb = '0; ck = '0;
    while (got_a.size() < 16 && budget > 0) begin
      if (pair_valid && pair_idx == 4'd3 && hold < 5) begin
        if (hold == 0) begin
          ca = A_out; cb = B_out; ck = pair_idx;
        end else if (A_out !== ca || B_out !== cb || pair_idx !== ck) begin
          unstable++;
        end
        pair_ready = 1'b0;
        hold++;
      end else begin
        pair_ready = 1'b1;
      end
      step(1);
      budget--;
    end
    pair_ready = 1'b1;
    checks++; if (hold != 5) $display("FAIL bp_hold_cycles got=%0d want=5", hold); else passed++;
    checks++; if (unstable != 0) $display("FAIL bp_stable got=%0d changes want=0", unstable); else passed++;
    checks++; if (got_a.size() != 16) $display("FAIL bp_count got=%0d want=16", got_a.size()); else passed++;
    k3 = 0;
    foreach (got_k[i]) if (got_k[i] == 3) k3++;
    checks++; if (k3 != 1) $display("FAIL bp_k3_once got=%0d want=1", k3); else passed++;
    if (got_a.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_k[i] !== exp_k[i])
          $display("FAIL bp_pair%0d got A=%h B=%h k=%0d want A=%h B=%h k=%0d", i, got_a[i], got_b[i], got_k[i], exp_a[i], exp_b[i], exp_k[i]);
        else passed++;
      end
    end
    step(3);
  endtask

  task automatic test_overflow();
    bit to;
    clear_mon();
    pair_ready = 1'b0;
    randomize_samples(96);
    expect_frame(0);
    expect_frame(1);
    for (int i = 0; i < 64; i++) send(smp[i], 0);
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_at64 got=%b want=0", overflow); else passed++;
    for (int i = 64; i < 96; i++) send(smp[i], 0);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_at96 got=%b want=1", overflow); else passed++;
    step(10);
    checks++; if (overflow !== 1'b1 || got_a.size() != 0) $display("FAIL ovf_hold got ovf=%b pairs=%0d want 1 0", overflow, got_a.size()); else passed++;
    pair_ready = 1'b1;
    wait_pairs(32, 200, to);
    checks++; if (to) $display("FAIL ovf_timeout got=%0d pairs want=32", got_a.size()); else passed++;
    if (!to) begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_k[i] !== exp_k[i])
          $display("FAIL ovf_pair%0d got A=%h B=%h k=%0d want A=%h B=%h k=%0d", i, got_a[i], got_b[i], got_k[i], exp_a[i], exp_b[i], exp_k[i]);
        else passed++;
      end
    end
    step(40);
    checks++; if (got_a.size() != 32) $display("FAIL ovf_no_extra got=%0d pairs want=32", got_a.size()); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", overflow); else passed++;
    checks++; if (fs_cnt != 2) $display("FAIL ovf_frame_start got=%0d want=2", fs_cnt); else passed++;
  endtask

  task automatic test_continuous();
    bit to;
    do_reset();
    checks++; if (overflow !== 1'b0) $display("FAIL cont_reset_ovf got=%b want=0", overflow); else passed++;
    clear_mon();
    pair_ready = 1'b1;
    randomize_samples(96);
    for (int f = 0; f < 3; f++) expect_frame(f);
    for (int i = 0; i < 96; i++) send(smp[i], 1);
    wait_pairs(48, 200, to);
    checks++; if (to) $display("FAIL cont_timeout got=%0d pairs want=48", got_a.size()); else passed++;
    if (!to) begin
      for (int i = 0; i < 48; i++) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_k[i] !== exp_k[i])
          $display("FAIL cont_pair%0d got A=%h B=%h k=%0d want A=%h B=%h k=%0d", i, got_a[i], got_b[i], got_k[i], exp_a[i], exp_b[i], exp_k[i]);
        else passed++;
      end
    end
    step(3);
    checks++; if (overflow !== 1'b0) $display("FAIL cont_overflow got=%b want=0", overflow); else passed++;
    checks++; if (fs_cnt != 3 || fd_cnt != 3) $display("FAIL cont_frames got fs=%0d fd=%0d want 3 3", fs_cnt, fd_cnt); else passed++;
  endtask

  task automatic test_mid_reset();
    bit to;
    int budget;
    clear_mon();
    pair_ready = 1'b1;
    randomize_samples(N);
    for (int i = 0; i < N; i++) send(smp[i], 0);
    budget = 100;
    while (!(pair_valid && pair_idx == 4'd7) && budget > 0) begin
      step(1);
      budget--;
    end
    checks++; if (!(pair_valid && pair_idx == 4'd7)) $display("FAIL mr_reach_k7 got v=%b k=%0d want 1 7", pair_valid, pair_idx); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (pair_valid !== 1'b0 || pair_idx !== '0) $display("FAIL mr_async_ctl got v=%b k=%0d want 0 0", pair_valid, pair_idx); else passed++;
    checks++; if (A_out !== '0 || B_out !== '0) $display("FAIL mr_async_data got A=%h B=%h want 0", A_out, B_out); else passed++;
    checks++; if (frame_start !== 1'b0 || overflow !== 1'b0) $display("FAIL mr_async_flags got fs=%b ovf=%b want 0 0", frame_start, overflow); else passed++;
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_mon();
    step(40);
    checks++; if (got_a.size() != 0 || pair_valid !== 1'b0) $display("FAIL mr_quiet got pairs=%0d v=%b want 0 0", got_a.size(), pair_valid); else passed++;
    randomize_samples(N);
    expect_frame(0);
    for (int i = 0; i < N - 1; i++) send(smp[i], int'($urandom_range(1)));
    step(10);
    checks++; if (got_a.size() != 0) $display("FAIL mr_31_samples got pairs=%0d want=0", got_a.size()); else passed++;
    send(smp[N-1], 0);
    wait_pairs(16, 100, to);
    checks++; if (to) $display("FAIL mr_timeout got=%0d pairs want=16", got_a.size()); else passed++;
    if (!to) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i] || got_k[i] !== exp_k[i])
          $display("FAIL mr_pair%0d got A=%h B=%h k=%0d want A=%h B=%h k=%0d", i, got_a[i], got_b[i], got_k[i], exp_a[i], exp_b[i], exp_k[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_extremes();
    test_backpressure();
    test_overflow();
    test_continuous();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish (%0d/%0d so far)", passed, checks);
    $fatal(1);
  end

endmodule
